ps2_keyboard_rx: RTL

- Receive-only PS/2 keyboard front end, upstream of the training-example logic on the UnAmiga board.
- Synchronises and debounces the raw clkps2/dataps2 pins, then deframes 11-bit device-to-host frames.
- Folds E0/F0 prefixes into flags and presents one key event per make/break code with a single-cycle valid strobe.
- Runs on the 25 MHz pixel clock domain.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_keyboard_rx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and FSM state encoding for the PS/2 keyboard receiver.
// Protocol-level constants only: no logic, no latency, no flow control.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CHECK
  } ps2_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus debounce for one raw PS/2 pin; output idles high.
// Latency: 2 + FILTER_LEN cycles per accepted level change; no backpressure.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive synchronised samples disagree with filt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      filt <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] != filt) begin
        if (cnt == CNT_LAST) begin
          filt <= sync[1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: filtered pins, 11-bit deframer, E0/F0 prefix fold into key events.
// Latency: strobes exactly 1 cycle after the stop-bit fall; no backpressure, all strobes single-cycle.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       key_valid,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       frame_err
);

  localparam int            TW            = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST        = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_DATA_BIT = 3'(PS2_FRAME_BITS - 4);

  logic          clk_f, dat_f, clk_prev, fall;
  ps2_state_t    state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          par_q, stop_q;
  logic [TW-1:0] tcnt;
  logic          ext_flag, brk_flag, err_q;
  logic [7:0]    rx_byte_q, scancode_q;
  logic          ext_q, rel_q;
  logic          in_frame, timeout, good, check_ok, check_bad, start_err, is_prefix;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (clkps2),
    .filt  (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (dataps2),
    .filt  (dat_f)
  );

  assign fall = clk_prev & ~clk_f;

  always_comb begin
    state_nxt = state;
    in_frame  = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
    timeout   = in_frame && (tcnt == T_LAST);
    good      = stop_q & (^{shift_q, par_q});
    check_ok  = (state == ST_CHECK) && good;
    check_bad = (state == ST_CHECK) && !good;
    // err_q guard keeps frame_err from pulsing twice in a row after a timeout
    start_err = (state == ST_IDLE) && fall && dat_f && !err_q;
    is_prefix = (shift_q == PS2_PREFIX_EXT) || (shift_q == PS2_PREFIX_BRK);

    case (state)
      ST_IDLE:   if (fall && !dat_f) state_nxt = ST_DATA;
      ST_DATA:   if (fall && (bit_cnt == LAST_DATA_BIT)) state_nxt = ST_PARITY;
      ST_PARITY: if (fall) state_nxt = ST_STOP;
      ST_STOP:   if (fall) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (timeout) state_nxt = ST_IDLE;

    byte_strobe = check_ok;
    key_valid   = check_ok && !is_prefix;
    frame_err   = start_err || check_bad || timeout;
    rx_byte     = check_ok  ? shift_q  : rx_byte_q;
    scancode    = key_valid ? shift_q  : scancode_q;
    extended    = key_valid ? ext_flag : ext_q;
    released    = key_valid ? brk_flag : rel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      clk_prev   <= 1'b1;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      tcnt       <= '0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      err_q      <= 1'b0;
      rx_byte_q  <= '0;
      scancode_q <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      state    <= state_nxt;
      clk_prev <= clk_f;
      err_q    <= frame_err;

      if ((state == ST_IDLE) || fall) tcnt <= '0;
      else if (tcnt != T_LAST)        tcnt <= tcnt + TW'(1);

      if (fall) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift_q <= {dat_f, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par_q  <= dat_f;
          ST_STOP:   stop_q <= dat_f;
          default:   ;
        endcase
      end

      if (check_bad || timeout) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (check_ok) begin
        if (shift_q == PS2_PREFIX_EXT)      ext_flag <= 1'b1;
        else if (shift_q == PS2_PREFIX_BRK) brk_flag <= 1'b1;
        else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end

      if (check_ok) rx_byte_q <= shift_q;
      if (key_valid) begin
        scancode_q <= shift_q;
        ext_q      <= ext_flag;
        rel_q      <= brk_flag;
      end
    end
  end

endmodule
